// File: rtl/maxnet_controller_pkg.sv
// Shared MAXNET definitions: neuron count, iteration limit and controller state encoding.
// Also reused by the datapath testbench.
package maxnet_controller_pkg;

   localparam int unsigned MAXNET_N        = 4;
   localparam int unsigned MAXNET_MAX_ITER = 15;
   localparam int unsigned ITER_W          = 4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_SETTLE = 3'd2,
      S_EVAL   = 3'd3,
      S_ITER   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/maxnet_controller_register.sv
// Generic register with load enable and synchronous clear (clear wins over enable).
module maxnet_controller_register #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_clr)
         r_q <= '0;
      else if (i_en)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/maxnet_controller.sv
// MAXNET competition sequencer: loads weights/inputs, iterates the lateral-inhibition
// update until at most one neuron stays active or MAX_ITER is reached, then reports.
module maxnet_controller
   import maxnet_controller_pkg::*;
#(
   parameter int unsigned N        = MAXNET_N,
   parameter int unsigned MAX_ITER = MAXNET_MAX_ITER
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N-1:0]      nz,
   output logic              ld_w,
   output logic              ld_x,
   output logic              iter_en,
   output logic              busy,
   output logic              done,
   output logic              valid,
   output logic [1:0]        winner,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              timeout
);

   localparam int unsigned         PW      = $clog2(N + 1);
   localparam logic [ITER_W-1:0]   MAX_CNT = ITER_W'(MAX_ITER);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PW-1:0]     w_pop;
   logic [1:0]        w_idx;
   logic              w_at_max;
   logic              w_cnt_clr;
   logic              r_valid;
   logic              r_timeout;
   logic [1:0]        r_winner;

   // Popcount and index of the (last) set bit; index is only used when popcount is 1.
   always_comb begin
      w_pop = '0;
      w_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (nz[i]) begin
            w_pop = w_pop + PW'(1);
            w_idx = 2'(i);
         end
      end
   end

   assign w_at_max  = (iter_cnt == MAX_CNT);
   assign w_cnt_clr = rst || (r_state == S_INIT);

   maxnet_controller_register #(.W(ITER_W)) u_iter_cnt (
      .clk   (clk),
      .i_clr (w_cnt_clr),
      .i_en  (iter_en),
      .i_d   (iter_cnt + ITER_W'(1)),
      .o_q   (iter_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ld_w        = 1'b0;
      ld_x        = 1'b0;
      iter_en     = 1'b0;
      done        = 1'b0;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:   if (start) w_state_nxt = S_INIT;
         S_INIT: begin
            ld_w        = 1'b1;
            ld_x        = 1'b1;
            w_state_nxt = S_SETTLE;
         end
         S_SETTLE: w_state_nxt = S_EVAL;
         S_EVAL: begin
            if ((w_pop <= PW'(1)) || w_at_max)
               w_state_nxt = S_DONE;
            else
               w_state_nxt = S_ITER;
         end
         S_ITER: begin
            iter_en     = 1'b1;
            w_state_nxt = S_SETTLE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Results are cleared in INIT, so only the unique-winner and timeout cases need writing.
   always_ff @(posedge clk) begin
      if (rst || (r_state == S_INIT)) begin
         r_valid   <= 1'b0;
         r_winner  <= '0;
         r_timeout <= 1'b0;
      end else if (r_state == S_EVAL) begin
         if (w_pop == PW'(1)) begin
            r_valid  <= 1'b1;
            r_winner <= w_idx;
         end else if ((w_pop != '0) && w_at_max) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign valid   = r_valid;
   assign winner  = r_winner;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_maxnet_controller.sv
// Randomized self-checking bench for maxnet_controller against a per-run outcome model
// (EVAL samples, latency, iteration count and result derived from the competition rules).
module tb_maxnet_controller;

   localparam int MAXI = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] nz;
   logic       ld_w, ld_x, iter_en, busy, done, valid, timeout;
   logic [1:0] winner;
   logic [3:0] iter_cnt;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] plan [0:15];

   always #5 clk = ~clk;

   maxnet_controller #(.N(4), .MAX_ITER(MAXI)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .nz       (nz),
      .ld_w     (ld_w),
      .ld_x     (ld_x),
      .iter_en  (iter_en),
      .busy     (busy),
      .done     (done),
      .valid    (valid),
      .winner   (winner),
      .iter_cnt (iter_cnt),
      .timeout  (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Outcome of one competition given the nz value seen at each successive EVAL.
   function automatic void model(output int k, output bit v, output bit to, output logic [1:0] w);
      k  = 0;
      v  = 1'b0;
      to = 1'b0;
      w  = 2'd0;
      for (int j = 0; j <= MAXI; j++) begin
         if ($countones(plan[j]) <= 1) begin
            k = j;
            if ($countones(plan[j]) == 1) begin
               v = 1'b1;
               for (int b = 0; b < 4; b++)
                  if (plan[j][b]) w = 2'(b);
            end
            return;
         end
         if (j == MAXI) begin
            k  = j;
            to = 1'b1;
            return;
         end
      end
   endfunction

   task automatic do_run(input string tag, input bit hold);
      int         k, done_t, iters, lds, bad_busy;
      bit         ev, et, seen;
      logic [1:0] ew;
      model(k, ev, et, ew);
      start = 1'b1;
      nz    = 4'($urandom);
      step();
      chk({tag, ".init_ld_w"}, ld_w, 1);
      chk({tag, ".init_ld_x"}, ld_x, 1);
      if (!hold) start = 1'b0;
      iters = 0; lds = 0; bad_busy = 0; seen = 1'b0; done_t = 0;
      for (int t = 1; t <= 3 + 3 * MAXI + 4 && !seen; t++) begin
         // Only EVAL edges (3, 6, 9, ...) carry meaningful data; the rest is noise.
         nz = (t % 3 == 0) ? plan[t / 3 - 1] : 4'($urandom);
         step();
         if (iter_en) iters++;
         if (ld_w || ld_x) lds++;
         if (!busy) bad_busy++;
         if (done) begin
            seen   = 1'b1;
            done_t = t;
         end
      end
      chk({tag, ".done_seen"}, seen, 1);
      chk({tag, ".latency"}, done_t, 3 + 3 * k);
      chk({tag, ".iter_pulses"}, iters, k);
      chk({tag, ".extra_loads"}, lds, 0);
      chk({tag, ".busy_run"}, bad_busy, 0);
      chk({tag, ".valid"}, valid, ev);
      chk({tag, ".winner"}, winner, ew);
      chk({tag, ".timeout"}, timeout, et);
      chk({tag, ".iter_cnt"}, iter_cnt, k);
      step();
      chk({tag, ".idle_busy"}, busy, 0);
      chk({tag, ".idle_done"}, done, 0);
      chk({tag, ".hold_res"}, {valid, timeout, winner}, {ev, et, ew});
      if (hold) begin
         step();
         chk({tag, ".restart_ld_w"}, ld_w, 1);
         start = 1'b0;
         rst   = 1'b1;
         step();
         chk({tag, ".abort_outs"},
             {busy, done, ld_w, ld_x, iter_en, valid, timeout, winner, iter_cnt}, 0);
         rst = 1'b0;
      end
   endtask

   initial begin
      int twos, quiet;
      rst   = 1'b1;
      start = 1'b1;
      nz    = 4'd0;
      step();
      step();
      chk("reset_outs", {busy, done, ld_w, ld_x, iter_en, valid, timeout, winner, iter_cnt}, 0);
      rst = 1'b0;

      plan[0] = 4'b0100;
      do_run("immediate", 1'b0);
      plan[0] = 4'b1011; plan[1] = 4'b1011; plan[2] = 4'b1000;
      do_run("two_iter", 1'b0);
      for (int j = 0; j <= MAXI; j++) plan[j] = 4'b0011;
      do_run("timeout", 1'b0);
      plan[0] = 4'b0000;
      do_run("all_zero", 1'b0);

      for (int r = 0; r < 30; r++) begin
         for (int j = 0; j < 16; j++)
            plan[j] = ($urandom_range(0, 2) == 0) ? 4'(4'b0001 << $urandom_range(0, 3))
                                                   : 4'($urandom);
         do_run("random", 1'b0);
      end

      // Abort during the second ITER.
      start = 1'b1;
      nz    = 4'b1011;
      step();
      start = 1'b0;
      twos  = 0;
      for (int t = 0; t < 20 && twos < 2; t++) begin
         step();
         if (iter_en) twos++;
      end
      chk("midrst.reach_iter2", twos, 2);
      rst = 1'b1;
      step();
      chk("midrst.outs", {busy, done, ld_w, ld_x, iter_en, valid, timeout, winner, iter_cnt}, 0);
      rst   = 1'b0;
      quiet = 0;
      for (int t = 0; t < 8; t++) begin
         step();
         if (done || busy) quiet++;
      end
      chk("midrst.no_done", quiet, 0);
      plan[0] = 4'b1110; plan[1] = 4'b0010;
      do_run("after_rst", 1'b0);

      plan[0] = 4'b1100; plan[1] = 4'b0001;
      do_run("held_start", 1'b1);
      plan[0] = 4'b1000;
      do_run("post_hold", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
